// File: rtl/antilog_pkg.sv
// Shared widths and FSM state encoding for the antilog converter.
// Optional rounding is enabled by defining ANTILOG_ROUND_EN.
package antilog_pkg;
    localparam int CHAR_W = 4;
    localparam int MANT_W = 7;
    localparam int OUT_W  = 16;
    localparam int ACC_W  = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/antilog_round.sv
// Round-half-up of the shifted accumulator onto the 16-bit integer grid.
// Only instantiated when ANTILOG_ROUND_EN is defined.
module antilog_round
    import antilog_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] out_data
);
    // Cannot overflow: when acc[6] can be set, the shift count is small.
    assign out_data = acc[ACC_W-1:MANT_W] + {{(OUT_W-1){1'b0}}, acc[MANT_W-1]};
endmodule

// File: rtl/antilog_calculator.sv
// Converts a log-domain operand (characteristic k, fraction f) to linear
// floor(({1,f} << k) / 128) by serial shifting. Macro: ANTILOG_ROUND_EN.
module antilog_calculator
    import antilog_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] char_in,
    input  logic [MANT_W-1:0] mant_in,
    input  logic              zero_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data
);
    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CHAR_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [OUT_W-1:0]   result;

`ifdef ANTILOG_ROUND_EN
    antilog_round u_round (
        .acc      (acc_q),
        .out_data (result)
    );
`else
    assign result = acc_q[ACC_W-1:MANT_W];
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = {{(ACC_W-MANT_W-1){1'b0}}, 1'b1, mant_in};
                    cnt_d = char_in;
                    if (zero_in) begin
                        out_data_d = '0;
                        state_d    = DONE;
                    end else begin
                        state_d    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = acc_q << 1;
                    cnt_d = cnt_q - {{(CHAR_W-1){1'b0}}, 1'b1};
                end else begin
                    out_data_d = result;
                    state_d    = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;
endmodule

// File: tb/tb_antilog_calculator.sv
// Directed bench for antilog_calculator with a cycle-level transaction model
// and per-cycle output comparison.
module tb_antilog_calculator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  char_in = '0;
    logic [6:0]  mant_in = '0;
    logic        zero_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;

    int checks   = 0;
    int failures = 0;

    antilog_calculator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .char_in   (char_in),
        .mant_in   (mant_in),
        .zero_in   (zero_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Value the operand must produce, from plain integer arithmetic.
    function automatic logic [15:0] antilog(input int k, input int f, input bit z);
        int unsigned v;
        int unsigned r;
        if (z) return 16'h0000;
        v = (32'd128 + f) << k;
        r = v >> 7;
`ifdef ANTILOG_ROUND_EN
        r = r + ((v >> 6) & 1);
`endif
        return r[15:0];
    endfunction

    // Transaction model: busy from accept until output handshake; result
    // becomes visible after the required number of edges.
    bit          m_busy = 1'b0;
    int          m_elapsed = 0;
    int          m_lat = 0;
    logic [15:0] m_exp = '0;
    bit          mon_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy    = 1'b1;
                m_elapsed = 1;
                m_lat     = zero_in ? 1 : int'(char_in) + 2;
                m_exp     = antilog(int'(char_in), int'(mant_in), zero_in);
            end
        end else if (m_elapsed >= m_lat) begin
            if (out_ready) m_busy = 1'b0;
        end else begin
            m_elapsed++;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
            chk("mon_out_valid", {31'b0, out_valid}, {31'b0, m_busy && (m_elapsed >= m_lat)});
            if (m_busy && m_elapsed >= m_lat)
                chk("mon_out_data", {16'b0, out_data}, {16'b0, m_exp});
        end
    end

    // Drive one operand from IDLE, wait for the result with a bound, check
    // literal data and latency, and let out_ready (held 1) complete it.
    task automatic do_op(input int k, input int f, input bit z,
                         input logic [15:0] exp_data, input int exp_lat);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        char_in  = k[3:0];
        mant_in  = f[6:0];
        zero_in  = z;
        @(negedge clk);
        in_valid = 1'b0;
        char_in  = ~char_in;
        mant_in  = ~mant_in;
        zero_in  = ~zero_in;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("op_valid_seen", {31'b0, out_valid}, 32'd1);
        chk("op_latency", lat, exp_lat);
        chk("op_data", {16'b0, out_data}, {16'b0, exp_data});
        $display("op k=%0d f=0x%02h z=%0d data=0x%04h lat=%0d", k, f, z, out_data, lat);
        @(negedge clk);
        chk("op_ready_after", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_data", {16'b0, out_data}, 32'd0);
        mon_en = 1'b1;

        // Model pinned against hand-computed values.
        chk("model_k3", {16'b0, antilog(3, 'h40, 0)}, 32'd12);
        chk("model_k15", {16'b0, antilog(15, 'h7F, 0)}, 32'hFF00);

        do_op(0, 'h00, 0, 16'd1, 2);
        do_op(3, 'h40, 0, 16'd12, 5);
        do_op(15, 'h7F, 0, 16'hFF00, 17);
`ifdef ANTILOG_ROUND_EN
        do_op(1, 'h60, 0, 16'd4, 3);
`else
        do_op(1, 'h60, 0, 16'd3, 3);
`endif
        do_op(9, 'h55, 1, 16'h0000, 1);
        do_op(7, 'h7F, 0, 16'd255, 9);
        do_op(2, 'h01, 0, 16'd4, 4);

        // Back-pressure in DONE with spurious new input.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; char_in = 4'd4; mant_in = 7'h20; zero_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 6);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; char_in = 4'd1; mant_in = 7'h00;
            chk("bp_hold_data", {16'b0, out_data}, 32'd20);
            chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        chk("bp_hold_data_end", {16'b0, out_data}, 32'd20);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_released_ready", {31'b0, in_ready}, 32'd1);
        $display("op k=4 f=0x20 z=0 backpressure data=20 released");

        // Reset two cycles into SHIFT of k=10.
        @(negedge clk);
        in_valid = 1'b1; char_in = 4'd10; mant_in = 7'h11; zero_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_out_data", {16'b0, out_data}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            chk("abort_no_stale", {31'b0, out_valid}, 32'd0);
        end
        $display("op k=10 f=0x11 z=0 aborted by reset");

        do_op(4, 'h20, 0, 16'd20, 6);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
